arbitro_prioridade_n: RTL and testbench

//  N-station priority arbiter: each station (IE) raises a request carrying a profile level and a

---
 rtl/arbitro_pkg.sv | 20 ++
 rtl/seletor_prioridade.sv | 60 ++++++
 rtl/arbitro_prioridade_n.sv | 160 ++++++++++++++++
 tb/tb_arbitro_prioridade_n.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared definitions for the priority arbiter: FSM encoding, RGB patterns and a
// width helper used to size indices and counters.
package arbitro_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // RGB patterns packed as {red, green, blue}; red is OR-ed in separately
    localparam logic [2:0] RGB_IDLE  = 3'b010;
    localparam logic [2:0] RGB_GRANT = 3'b001;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/seletor_prioridade.sv
// Combinational winner selection: highest level among eligible stations, ties
// broken by the first matching index at or after rr_ptr, wrapping around.
module seletor_prioridade
    import arbitro_pkg::*;
#(
    parameter int N        = 2,
    parameter int PERFIL_W = 3,
    parameter int IDX_W    = 1
)
(
    input  logic [N-1:0]          eligible,
    input  logic [N*PERFIL_W-1:0] perfil,
    input  logic [IDX_W-1:0]      rr_ptr,
    output logic                  valid,
    output logic                  tie,
    output logic [IDX_W-1:0]      win_idx,
    output logic [PERFIL_W-1:0]   win_perfil
);

    logic [PERFIL_W-1:0] max_lvl;
    logic [N-1:0]        at_max;
    logic                found;

    always_comb begin
        max_lvl = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && (perfil[i*PERFIL_W +: PERFIL_W] > max_lvl))
                max_lvl = perfil[i*PERFIL_W +: PERFIL_W];
        end
    end

    always_comb begin
        at_max = '0;
        for (int i = 0; i < N; i++)
            at_max[i] = eligible[i] && (perfil[i*PERFIL_W +: PERFIL_W] == max_lvl);
    end

    // First pass covers indices from rr_ptr upward, second pass wraps to the start
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && at_max[i] && (i >= int'(rr_ptr))) begin
                found   = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && at_max[i]) begin
                found   = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

    assign valid      = |eligible;
    assign tie        = (at_max & (at_max - {{(N-1){1'b0}}, 1'b1})) != '0;
    assign win_perfil = max_lvl;

endmodule

// File: rtl/arbitro_prioridade_n.sv
// N-station priority arbiter with minimum hold, preemption by higher levels,
// timeout with per-station lockout and a registered RGB status indicator.
module arbitro_prioridade_n
    import arbitro_pkg::*;
#(
    parameter int N        = 2,
    parameter int PERFIL_W = 3,
    parameter int FUNC_W   = 4,
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 64,
    localparam int IDX_W   = (clog2(N) < 1) ? 1 : clog2(N),
    localparam int HOLD_W  = clog2(MAX_HOLD + 1)
)
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N-1:0]          req,
    input  logic [N*PERFIL_W-1:0] perfil,
    input  logic [N*FUNC_W-1:0]   funcao,
    output logic [N-1:0]          grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic [FUNC_W-1:0]     grant_funcao,
    output logic [PERFIL_W-1:0]   grant_perfil,
    output logic                  LEDRGB_red,
    output logic                  LEDRGB_green,
    output logic                  LEDRGB_blue
);

    logic [1:0]          state, state_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [IDX_W-1:0]    rr_ptr, rr_n;
    logic [N-1:0]        lockout, lockout_n;
    logic [N-1:0]        nonzero, eligible;
    logic [N-1:0]        grant_n, sel_onehot;
    logic [IDX_W-1:0]    idx_n, sel_idx;
    logic [FUNC_W-1:0]   func_n, sel_funcao;
    logic [PERFIL_W-1:0] perf_n, sel_perfil;
    logic                sel_valid, sel_tie, red_n, load, release_grant;

    always_comb begin
        nonzero = '0;
        for (int i = 0; i < N; i++)
            nonzero[i] = |perfil[i*PERFIL_W +: PERFIL_W];
    end

    assign eligible = req & ~lockout & nonzero;

    seletor_prioridade #(
        .N        (N),
        .PERFIL_W (PERFIL_W),
        .IDX_W    (IDX_W)
    ) u_seletor (
        .eligible   (eligible),
        .perfil     (perfil),
        .rr_ptr     (rr_ptr),
        .valid      (sel_valid),
        .tie        (sel_tie),
        .win_idx    (sel_idx),
        .win_perfil (sel_perfil)
    );

    always_comb begin
        sel_onehot = '0;
        sel_funcao = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_funcao    = funcao[i*FUNC_W +: FUNC_W];
            end
        end
    end

    // Next-state: a release clears the grant, a load (fresh or preempting) latches the winner
    always_comb begin
        state_n       = state;
        grant_n       = grant;
        idx_n         = grant_idx;
        func_n        = grant_funcao;
        perf_n        = grant_perfil;
        hold_n        = hold_cnt;
        rr_n          = rr_ptr;
        lockout_n     = lockout & req;
        red_n         = 1'b0;
        load          = 1'b0;
        release_grant = 1'b0;

        case (state)
            ST_IDLE: begin
                if (sel_valid)
                    load = 1'b1;
            end
            ST_GRANT: begin
                if (!req[grant_idx]) begin
                    release_grant = 1'b1;
                end else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
                    release_grant        = 1'b1;
                    lockout_n[grant_idx] = 1'b1;
                end else if ((hold_cnt >= HOLD_W'(MIN_HOLD)) && sel_valid &&
                             (sel_perfil > grant_perfil)) begin
                    load = 1'b1;
                end else begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (load) begin
            state_n = ST_GRANT;
            grant_n = sel_onehot;
            idx_n   = sel_idx;
            func_n  = sel_funcao;
            perf_n  = sel_perfil;
            hold_n  = HOLD_W'(1);
            red_n   = sel_tie;
        end

        if (release_grant) begin
            state_n = ST_GAP;
            grant_n = '0;
            idx_n   = '0;
            func_n  = '0;
            perf_n  = '0;
            hold_n  = '0;
            rr_n    = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // RGB is loaded from the next grant so it lines up with the grant outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            grant        <= '0;
            grant_idx    <= '0;
            grant_funcao <= '0;
            grant_perfil <= '0;
            hold_cnt     <= '0;
            rr_ptr       <= '0;
            lockout      <= '0;
            {LEDRGB_red, LEDRGB_green, LEDRGB_blue} <= RGB_IDLE;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            grant_idx    <= idx_n;
            grant_funcao <= func_n;
            grant_perfil <= perf_n;
            hold_cnt     <= hold_n;
            rr_ptr       <= rr_n;
            lockout      <= lockout_n;
            {LEDRGB_red, LEDRGB_green, LEDRGB_blue} <=
                ((grant_n == '0) ? RGB_IDLE : RGB_GRANT) | {red_n, 2'b00};
        end
    end

endmodule

// File: tb/tb_arbitro_prioridade_n.sv
// Self-checking bench for arbitro_prioridade_n: directed scenarios followed by a
// random sweep, all compared against a cycle-level behavioural model.
module tb_arbitro_prioridade_n;

    localparam int N        = 4;
    localparam int PERFIL_W = 3;
    localparam int FUNC_W   = 4;
    localparam int MIN_HOLD = 4;
    localparam int MAX_HOLD = 8;

    logic                  CLK;
    logic                  RST;
    logic [N-1:0]          req;
    logic [N*PERFIL_W-1:0] perfil;
    logic [N*FUNC_W-1:0]   funcao;
    logic [N-1:0]          grant;
    logic [1:0]            grant_idx;
    logic [FUNC_W-1:0]     grant_funcao;
    logic [PERFIL_W-1:0]   grant_perfil;
    logic                  LEDRGB_red;
    logic                  LEDRGB_green;
    logic                  LEDRGB_blue;

    logic [PERFIL_W-1:0] lvl [N];
    logic [FUNC_W-1:0]   fn  [N];

    int n_checks;
    int n_fail;

    // Model: owner -1 means no grant; cool marks the single forced-idle cycle after a release
    int          m_owner;
    int          m_cool;
    int          m_hold;
    int          m_rr;
    int          m_func;
    int          m_perf;
    bit          m_red;
    logic [N-1:0] m_lock;

    arbitro_prioridade_n #(
        .N        (N),
        .PERFIL_W (PERFIL_W),
        .FUNC_W   (FUNC_W),
        .MIN_HOLD (MIN_HOLD),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req          (req),
        .perfil       (perfil),
        .funcao       (funcao),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .grant_funcao (grant_funcao),
        .grant_perfil (grant_perfil),
        .LEDRGB_red   (LEDRGB_red),
        .LEDRGB_green (LEDRGB_green),
        .LEDRGB_blue  (LEDRGB_blue)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [N-1:0] r);
        req = r;
        for (int i = 0; i < N; i++) begin
            perfil[i*PERFIL_W +: PERFIL_W] = lvl[i];
            funcao[i*FUNC_W +: FUNC_W]     = fn[i];
        end
    endtask

    // Highest level wins; among equals, the smallest circular distance from rr wins
    task automatic pick(output int w, output int best, output bit tied);
        int cnt;
        int bestd;
        int d;
        w     = -1;
        best  = 0;
        cnt   = 0;
        bestd = N;
        for (int i = 0; i < N; i++)
            if (req[i] && !m_lock[i] && lvl[i] != 0 && int'(lvl[i]) > best)
                best = int'(lvl[i]);
        for (int i = 0; i < N; i++) begin
            if (req[i] && !m_lock[i] && lvl[i] != 0 && int'(lvl[i]) == best) begin
                cnt++;
                d = (i - m_rr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    w     = i;
                end
            end
        end
        tied = (cnt > 1);
    endtask

    task automatic model_step();
        int w;
        int best;
        bit tied;
        logic [N-1:0] nl;
        if (RST) begin
            m_owner = -1;
            m_cool  = 0;
            m_hold  = 0;
            m_rr    = 0;
            m_lock  = '0;
            m_func  = 0;
            m_perf  = 0;
            m_red   = 0;
            return;
        end
        pick(w, best, tied);
        nl    = m_lock & req;
        m_red = 0;
        if (m_owner < 0) begin
            if (m_cool != 0) begin
                m_cool = 0;
            end else if (w >= 0) begin
                m_owner = w; m_hold = 1; m_func = int'(fn[w]); m_perf = best; m_red = tied;
            end
        end else if (!req[m_owner] || m_hold == MAX_HOLD) begin
            if (req[m_owner]) nl[m_owner] = 1'b1;
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
            m_cool  = 1;
            m_hold  = 0;
        end else if (m_hold >= MIN_HOLD && best > m_perf) begin
            m_owner = w; m_hold = 1; m_func = int'(fn[w]); m_perf = best; m_red = tied;
        end else begin
            m_hold++;
        end
        m_lock = nl;
    endtask

    task automatic compare_model();
        logic [N-1:0] exp_grant;
        exp_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check_output("grant", 32'(grant), 32'(exp_grant));
        check_output("onehot0", 32'($onehot0(grant)), 32'd1);
        check_output("green", 32'(LEDRGB_green), 32'(m_owner < 0));
        check_output("blue", 32'(LEDRGB_blue), 32'(m_owner >= 0));
        check_output("red", 32'(LEDRGB_red), 32'(m_red));
        if (m_owner >= 0) begin
            check_output("grant_idx", 32'(grant_idx), 32'(m_owner));
            check_output("grant_funcao", 32'(grant_funcao), 32'(m_func));
            check_output("grant_perfil", 32'(grant_perfil), 32'(m_perf));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [N-1:0] r;
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        for (int i = 0; i < N; i++) begin
            lvl[i] = '0;
            fn[i]  = FUNC_W'(i + 1);
        end
        apply_stimulus('0);
        tick();
        tick();
        check_output("reset_grant", 32'(grant), 32'd0);
        check_output("reset_rgb", 32'({LEDRGB_red, LEDRGB_green, LEDRGB_blue}), 32'b010);
        RST = 1'b0;

        $display("[TB] single request");
        lvl[0] = 3'd3; fn[0] = 4'hA;
        apply_stimulus(4'b0001);
        tick();
        check_output("t1_grant", 32'(grant), 32'b0001);
        check_output("t1_funcao", 32'(grant_funcao), 32'hA);
        check_output("t1_blue", 32'(LEDRGB_blue), 32'd1);
        check_output("t1_green", 32'(LEDRGB_green), 32'd0);
        apply_stimulus(4'b0000);
        tick();
        tick();

        $display("[TB] equal levels round robin");
        do_reset();
        lvl[0] = 3'd2; lvl[1] = 3'd2;
        apply_stimulus(4'b0011);
        tick();
        check_output("t2_grant", 32'(grant), 32'b0001);
        check_output("t2_red", 32'(LEDRGB_red), 32'd1);
        tick();
        check_output("t2_red_pulse", 32'(LEDRGB_red), 32'd0);
        apply_stimulus(4'b0010);
        tick();
        check_output("t2_gap", 32'(grant), 32'd0);
        tick();
        tick();
        check_output("t2_rr_grant", 32'(grant), 32'b0010);

        $display("[TB] preemption after minimum hold");
        do_reset();
        lvl[0] = 3'd2; lvl[1] = 3'd5;
        apply_stimulus(4'b0001);
        tick();
        tick();
        apply_stimulus(4'b0011);
        tick();
        check_output("t3_protected", 32'(grant), 32'b0001);
        tick();
        tick();
        check_output("t3_preempt", 32'(grant), 32'b0010);
        check_output("t3_perfil", 32'(grant_perfil), 32'd5);

        $display("[TB] timeout and lockout");
        do_reset();
        lvl[0] = 3'd3;
        apply_stimulus(4'b0001);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (grant == 4'b0001) cnt++;
        end
        check_output("t4_hold_len", 32'(cnt), 32'(MAX_HOLD));
        apply_stimulus(4'b0000);
        tick();
        apply_stimulus(4'b0001);
        tick();
        check_output("t4_regrant", 32'(grant), 32'b0001);

        $display("[TB] zero level never granted");
        do_reset();
        lvl[0] = 3'd0;
        apply_stimulus(4'b0001);
        for (int k = 0; k < 5; k++) tick();
        check_output("t5_green", 32'(LEDRGB_green), 32'd1);

        $display("[TB] reset mid-grant");
        lvl[2] = 3'd4; fn[2] = 4'h7;
        apply_stimulus(4'b0100);
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_output("t6_grant", 32'(grant), 32'd0);
        check_output("t6_idx", 32'(grant_idx), 32'd0);
        check_output("t6_funcao", 32'(grant_funcao), 32'd0);
        check_output("t6_perfil", 32'(grant_perfil), 32'd0);
        check_output("t6_rgb", 32'({LEDRGB_red, LEDRGB_green, LEDRGB_blue}), 32'b010);

        $display("[TB] random sweep");
        r = '0;
        for (int k = 0; k < 600; k++) begin
            RST = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
                if ($urandom_range(0, 9) == 0) lvl[i] = PERFIL_W'($urandom_range(0, 7));
                fn[i] = FUNC_W'($urandom_range(0, 15));
            end
            apply_stimulus(r);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
